// File: rtl/alu_pkg.sv
// Shared opcodes, tag width and command layout for the ALU issue path.
package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam int TAG_W = 8;
    localparam int ALU_W = 8;

    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Generic synchronous FIFO; full/empty are derived from the occupancy count.
module alu_cmd_fifo #(
    parameter int WIDTH_DATA = 8,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH_DATA-1:0]      push_data,
    input  logic                       pop,
    output logic [WIDTH_DATA-1:0]      pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH_DATA-1:0] mem_q [DEPTH];
    logic [WIDTH_DATA-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push_ok, pop_ok;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Buffers ALU commands, drives the FIFO head into the external ALU and
// registers its result with opcode and sequence tag behind valid/ready.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic [1:0]             in_op,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [1:0]             alu_op,
    input  logic [WIDTH-1:0]       alu_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_result,
    output logic [1:0]             out_op,
    output logic [TAG_W-1:0]       out_tag,
    output logic [$clog2(DEPTH):0] count
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    cmd_t             push_cmd, head;
    logic [CMD_W-1:0] head_raw;
    logic             full, empty, push, capture;

    logic [TAG_W-1:0] tag_cnt_q, tag_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic [1:0]       out_op_q, out_op_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    // in_ready is a function of registered state and reset only
    assign in_ready = rst_n & ~full;
    assign push     = in_valid & in_ready;
    assign capture  = ~empty & (~out_valid_q | out_ready);
    assign head     = cmd_t'(head_raw);

    assign push_cmd = '{a: in_a, b: in_b, op: in_op, tag: tag_cnt_q};

    alu_cmd_fifo #(
        .WIDTH_DATA (CMD_W),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_cmd),
        .pop       (capture),
        .pop_data  (head_raw),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign alu_a  = empty ? '0 : head.a;
    assign alu_b  = empty ? '0 : head.b;
    assign alu_op = empty ? ALU_ADD : head.op;

    always_comb begin
        tag_cnt_d    = tag_cnt_q + TAG_W'(push);
        out_valid_d  = out_valid_q & ~out_ready;
        out_result_d = out_result_q;
        out_op_d     = out_op_q;
        out_tag_d    = out_tag_q;
        if (capture) begin
            out_valid_d  = 1'b1;
            out_result_d = alu_result;
            out_op_d     = head.op;
            out_tag_d    = head.tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_cnt_q    <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_op_q     <= '0;
            out_tag_q    <= '0;
        end else begin
            tag_cnt_q    <= tag_cnt_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_op_q     <= out_op_d;
            out_tag_q    <= out_tag_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_op     = out_op_q;
    assign out_tag    = out_tag_q;

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Upstream issue stage for the 8-bit combinational `alu`. It accepts ALU commands (operands plus opcode) over a valid/ready handshake and buffers them in a small FIFO. It drives the FIFO head onto the ALU inputs, registers the ALU result together with the opcode and a sequence tag, and presents that on a valid/ready output port. This turns the purely combinational ALU into a back-pressured, one-result-per-cycle pipeline stage.

## Interface
- `WIDTH`, default 8: operand and result width; must match `alu`.
- `DEPTH`, default 4: command FIFO depth; power of two, ≥ 2.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  command present.
- `in_ready`  out  1  queue can accept; equals (count < DEPTH) and rst_n high.
- `in_a`, `in_b`  in  WIDTH  operands.
- `in_op`  in  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 OR.
- `alu_a`, `alu_b`  out  WIDTH  FIFO head operands to `alu`; 0 when empty.
- `alu_op`  out  2  FIFO head opcode; 00 when empty.
- `alu_result`  in  WIDTH  combinational result from `alu`.
- `out_valid`  out  1  registered result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_result`  out  WIDTH  registered ALU result.
- `out_op`  out  2  opcode that produced `out_result`.
- `out_tag`  out  8  sequence number of the command.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy; excludes the output register.

## Operation
- Push: on `in_valid & in_ready`, write {a, b, op, tag} at the write pointer and increment `tag_cnt`. `tag_cnt` is 8 bits, wraps 255→0, and the first command after reset carries tag 0.
- Head drive: `alu_a/alu_b/alu_op` come combinationally from the FIFO head entry, and are forced to 0 when the FIFO is empty.
- Capture: when the FIFO is non-empty and (`!out_valid | out_ready`), load `out_result ← alu_result`, `out_op ← head.op` and `out_tag ← head.tag`. Set `out_valid` to 1 and pop the head.
- Drain: when `out_valid & out_ready` and the FIFO is empty, clear `out_valid`. The `out_*` data holds its last value.
- Stall: when `out_valid & !out_ready`, all output registers hold and the head is not popped. Pushes continue until the FIFO is full.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance.
- Push when full is impossible because `in_ready` is 0. A push into an empty FIFO is not bypassed to the output in the same cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are derived from `count`.
- Arithmetic is performed by `alu`: ADD/SUB are modulo 2^WIDTH, and carry/borrow are discarded.

## Timing
- Reset asserted, at any time including mid-stream:
  - `count` = 0, pointers = 0, `tag_cnt` = 0.
  - `out_valid` = 0, `out_result` = 0, `out_op` = 0, `out_tag` = 0.
  - `in_ready` = 0.
  - Buffered commands are discarded.
- First edge after release: `in_ready` = 1.
- Latency: a command accepted at edge k reaches the FIFO head after k. It is captured at edge k+1 if the output slot is free, so `out_valid` is high after edge k+1.
- Throughput: one command per cycle when `out_ready` is held high.
- Capacity: DEPTH + 1 commands in flight (FIFO plus output register).
- `in_ready` depends only on registered state and `rst_n`; it has no combinational path from `out_ready`.

## Structure
- Package `alu_pkg`:
  - opcode localparams `ALU_ADD`=2'b00, `ALU_SUB`=2'b01, `ALU_AND`=2'b10, `ALU_OR`=2'b11;
  - `TAG_W`=8;
  - packed command struct {a, b, op, tag}.
- Sub-module `alu_cmd_fifo`: a generic synchronous FIFO (parameters WIDTH_DATA, DEPTH; push/pop/full/empty/count; asynchronous active-low reset). `alu_issue_queue` instantiates it and holds the tag counter and output register.
- `alu` is instantiated by the integrating top level, not inside this block.

## Test plan
- Reset, then push (3, 5, ADD) with `out_ready` = 1 → `alu_op` = 00 one cycle later. Next edge: `out_valid` = 1, `out_result` = 8, `out_tag` = 0.
- Push 6 back-to-back commands with `out_ready` = 0 and DEPTH = 4:
  - `in_ready` falls after the 5th accept (4 in the FIFO, 1 in the output register);
  - then raise `out_ready` → results appear in order with tags 0..4.
- Push (2, 3, SUB), then (0xF0, 0x3C, AND), then (0xF0, 0x0F, OR) → results 0xFF, 0x30, 0xFF with `out_op` 01, 10, 11.
- Push 256 commands, then 1 more → tags run 0..255 and the 257th carries tag 0.
- With 3 commands queued and `out_valid` = 1, assert `rst_n` = 0 mid-stream → `out_valid`, `count` and `in_ready` are 0 immediately. After release no stale result appears, and the next tag is 0.
- Steady stream with `out_ready` toggling every cycle → no loss or duplication: the output tag sequence is strictly consecutive, and `count` never exceeds DEPTH.
